// File: rtl/mpg_pkg.sv
// Shared types and helpers for the multi-pulse gate driver.
//   state_e : burst sequencer states
//   clamp1  : maps a zero width to one cycle so every programmed phase lasts at least one clock
package mpg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } state_e;

  // Widest width value clamp1 accepts; callers cast in and out.
  localparam int unsigned ClampW = 64;

  function automatic logic [ClampW-1:0] clamp1(input logic [ClampW-1:0] x);
    return (x == '0) ? ClampW'(1) : x;
  endfunction

endpackage

// File: rtl/pulse_edge_det.sv
// Registered rising-edge detector.
//   clk   : clock
//   rst_n : asynchronous active-low reset (clears the delayed copy)
//   d     : input, already synchronous to clk
//   rise  : high while d is 1 and was 0 on the previous clock
module pulse_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/multi_pulse_gen.sv
// Multi-pulse gate driver for power-stage switching tests.
// A rising edge on tem emits a burst of n_pulses pulses on k1, each t_high cycles active
// separated by t_low idle cycles; widths and count are latched when the trigger is accepted.
//   clk, rst_n         : clock, asynchronous active-low reset
//   enable             : run permit; low aborts any burst and holds idle
//   tem                : burst trigger (rising edge)
//   n_pulses           : pulses per burst (0 = ignore trigger)
//   t_high, t_low      : active / gap widths in clocks (0 treated as 1)
//   k1                 : gate drive
//   k2                 : one-cycle strobe when k1 returns idle after the last pulse
//   busy               : burst in progress
//   done               : one-cycle strobe on normal burst completion
module multi_pulse_gen
  import mpg_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned NP_W      = 4,
  parameter bit          K1_ACTIVE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             tem,
  input  logic [NP_W-1:0]  n_pulses,
  input  logic [CNT_W-1:0] t_high,
  input  logic [CNT_W-1:0] t_low,
  output logic             k1,
  output logic             k2,
  output logic             busy,
  output logic             done
);

  localparam logic K1Idle = ~K1_ACTIVE;

  logic             tem_rise;
  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] th_d, th_q;
  logic [CNT_W-1:0] tl_d, tl_q;
  logic [NP_W-1:0]  rem_d, rem_q;
  logic             k1_d, k1_q;
  logic             k2_d, k2_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;

  pulse_edge_det u_tem_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (tem),
    .rise (tem_rise)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    th_d    = th_q;
    tl_d    = tl_q;
    rem_d   = rem_q;
    k1_d    = k1_q;
    busy_d  = busy_q;
    k2_d    = 1'b0;
    done_d  = 1'b0;

    if (!enable) begin
      // Abort: drop to idle without any completion strobe.
      state_d = StIdle;
      cnt_d   = '0;
      k1_d    = K1Idle;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (tem_rise && (n_pulses != '0)) begin
            state_d = StHigh;
            cnt_d   = '0;
            th_d    = CNT_W'(clamp1(ClampW'(t_high)));
            tl_d    = CNT_W'(clamp1(ClampW'(t_low)));
            rem_d   = n_pulses;
            k1_d    = K1_ACTIVE;
            busy_d  = 1'b1;
          end
        end
        StHigh: begin
          // Compare against width-1 so a full-scale width never needs the counter to wrap.
          if (cnt_q == th_q - CNT_W'(1)) begin
            cnt_d = '0;
            k1_d  = K1Idle;
            if (rem_q == NP_W'(1)) begin
              state_d = StIdle;
              busy_d  = 1'b0;
              k2_d    = 1'b1;
              done_d  = 1'b1;
            end else begin
              state_d = StLow;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StLow: begin
          if (cnt_q == tl_q - CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = StHigh;
            k1_d    = K1_ACTIVE;
            rem_d   = rem_q - NP_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
          k1_d    = K1Idle;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      th_q    <= '0;
      tl_q    <= '0;
      rem_q   <= '0;
      k1_q    <= K1Idle;
      k2_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      th_q    <= th_d;
      tl_q    <= tl_d;
      rem_q   <= rem_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign k1   = k1_q;
  assign k2   = k2_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Bench for multi_pulse_gen: two instances (active-high and active-low k1) share stimulus.
// Expected {k1 active, k2, busy, done} per clock is queued when stimulus is applied and
// popped 1 ns after each rising edge.
module tb_multi_pulse_gen;

  localparam int unsigned CntW = 32;
  localparam int unsigned NpW  = 4;

  // Expected-vector encodings: {k1 active, k2, busy, done}
  localparam logic [3:0] ExpIdle   = 4'b0000;
  localparam logic [3:0] ExpHigh   = 4'b1010;
  localparam logic [3:0] ExpGap    = 4'b0010;
  localparam logic [3:0] ExpStrobe = 4'b0101;

  logic            clk;
  logic            rst_n;
  logic            enable;
  logic            tem;
  logic [NpW-1:0]  n_pulses;
  logic [CntW-1:0] t_high;
  logic [CntW-1:0] t_low;
  logic            k1_a, k2_a, busy_a, done_a;
  logic            k1_b, k2_b, busy_b, done_b;

  logic [3:0]  exp_q[$];
  int unsigned n_vec;
  int unsigned n_err;
  string       cur_test;

  multi_pulse_gen #(
    .CNT_W    (CntW),
    .NP_W     (NpW),
    .K1_ACTIVE(1'b1)
  ) u_dut_hi (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .tem     (tem),
    .n_pulses(n_pulses),
    .t_high  (t_high),
    .t_low   (t_low),
    .k1      (k1_a),
    .k2      (k2_a),
    .busy    (busy_a),
    .done    (done_a)
  );

  multi_pulse_gen #(
    .CNT_W    (CntW),
    .NP_W     (NpW),
    .K1_ACTIVE(1'b0)
  ) u_dut_lo (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .tem     (tem),
    .n_pulses(n_pulses),
    .t_high  (t_high),
    .t_low   (t_low),
    .k1      (k1_b),
    .k2      (k2_b),
    .busy    (busy_b),
    .done    (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Scoreboard consumer.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        logic [3:0] e;
        e = exp_q.pop_front();
        chk({cur_test, "/hi"}, 32'({k1_a, k2_a, busy_a, done_a}), 32'(e));
        chk({cur_test, "/lo"}, 32'({~k1_b, k2_b, busy_b, done_b}), 32'(e));
      end
    end
  end

  function automatic int burst_len(input int n, input int th, input int tl);
    return n * th + (n - 1) * tl + 1;
  endfunction

  // Queue burst vectors with index in [from, to); index 0 is the clock after the trigger edge.
  task automatic push_burst(input int n, input int th, input int tl, input int from,
                            input int to);
    int idx;
    idx = 0;
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < th; i++) begin
        if (idx >= from && idx < to) exp_q.push_back(ExpHigh);
        idx++;
      end
      if (p != n - 1) begin
        for (int i = 0; i < tl; i++) begin
          if (idx >= from && idx < to) exp_q.push_back(ExpGap);
          idx++;
        end
      end
    end
    if (idx >= from && idx < to) exp_q.push_back(ExpStrobe);
  endtask

  // Optionally fire a trigger with the given config, queue the expected slice, and wait it out.
  task automatic run(input int n, input int th, input int tl, input int from, input int to,
                     input bit trig);
    int th_e;
    int tl_e;
    th_e = (th == 0) ? 1 : th;
    tl_e = (tl == 0) ? 1 : tl;
    if (trig) begin
      tem      = 1'b1;
      n_pulses = NpW'(n);
      t_high   = CntW'(th);
      t_low    = CntW'(tl);
    end
    push_burst(n, th_e, tl_e, from, to);
    repeat (to - from) begin
      @(negedge clk);
      tem = 1'b0;
    end
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      exp_q.push_back(ExpIdle);
      @(negedge clk);
    end
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    cur_test = "reset";
    rst_n    = 1'b1;
    enable   = 1'b0;
    tem      = 1'b0;
    n_pulses = '0;
    t_high   = '0;
    t_low    = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset/hi", 32'({k1_a, k2_a, busy_a, done_a}), 32'(ExpIdle));
    chk("reset/lo", 32'({~k1_b, k2_b, busy_b, done_b}), 32'(ExpIdle));
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    idle(3);

    cur_test = "t1_n2";
    run(2, 1200, 800, 0, burst_len(2, 1200, 800), 1'b1);
    idle(2);

    cur_test = "t2_n5";
    run(5, 3, 2, 0, burst_len(5, 3, 2), 1'b1);
    idle(2);

    // Retrigger mid-pulse with different inputs: must be ignored, latched values kept.
    cur_test = "t3_busy_retrig";
    run(2, 1200, 800, 0, 600, 1'b1);
    tem      = 1'b1;
    n_pulses = NpW'(9);
    t_high   = CntW'(5);
    t_low    = CntW'(7);
    run(2, 1200, 800, 600, burst_len(2, 1200, 800), 1'b0);
    idle(1);
    cur_test = "t3_fresh";
    run(1, 4, 4, 0, burst_len(1, 4, 4), 1'b1);
    idle(2);

    // Abort inside the first gap (index 5 is gap cycle 2 with t_high=4).
    cur_test = "t4_abort";
    run(3, 4, 6, 0, 6, 1'b1);
    enable = 1'b0;
    idle(2);
    cur_test = "t4_blocked";
    tem      = 1'b1;
    n_pulses = NpW'(2);
    idle(2);
    tem = 1'b0;
    idle(2);
    cur_test = "t4_enable_edge";
    enable   = 1'b1;
    run(2, 3, 2, 0, burst_len(2, 3, 2), 1'b1);
    idle(2);

    cur_test = "t5_clamp";
    run(3, 0, 0, 0, burst_len(3, 1, 1), 1'b1);
    idle(2);
    cur_test = "t5_n0";
    tem      = 1'b1;
    n_pulses = '0;
    t_high   = CntW'(4);
    idle(3);
    tem = 1'b0;
    idle(2);

    // Asynchronous reset in the middle of the first pulse.
    cur_test = "t6_rst";
    run(2, 10, 10, 0, 5, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async/hi", 32'({k1_a, k2_a, busy_a, done_a}), 32'(ExpIdle));
    chk("t6_async/lo", 32'({~k1_b, k2_b, busy_b, done_b}), 32'(ExpIdle));
    idle(4);
    rst_n = 1'b1;
    idle(3);
    cur_test = "t6_after";
    run(2, 2, 3, 0, burst_len(2, 2, 3), 1'b1);
    idle(2);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
